// File: rtl/pulse_accum_buf.sv
// Coherent pulse integrator: accumulates N_CH signed channels over n_pulses pulses in a local RAM
// and streams the windowed, shifted and saturated sums out through a 4-entry AXI-Stream FIFO.
module pulse_accum_buf #(
  parameter int IN_WIDTH   = 16,
  parameter int N_CH       = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic [15:0]               n_pulses,
  input  logic [ADDR_WIDTH:0]       n_samples,
  input  logic [ADDR_WIDTH-1:0]     start_index,
  input  logic [ADDR_WIDTH-1:0]     end_index,
  input  logic [4:0]                out_shift,
  input  logic [N_CH*IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [N_CH*OUT_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [31:0]               frame_count,
  output logic                      sat_flag
);
  localparam int AW = N_CH * ACC_WIDTH;
  localparam int OW = N_CH * OUT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [ACC_WIDTH-1:0] sext_fn(input logic signed [IN_WIDTH-1:0] x);
    return ACC_WIDTH'(x);
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] shr_fn(input logic signed [ACC_WIDTH-1:0] v,
                                                        input logic [4:0] sh);
    return v >>> sh;
  endfunction

  function automatic logic clip_fn(input logic signed [ACC_WIDTH-1:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_fn(input logic signed [ACC_WIDTH-1:0] v);
    if (v > ACC_MAX) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    if (v < ACC_MIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    return v[OUT_WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DUMP} state_t;
  state_t                state_q;
  logic [15:0]           pidx_q, npl_q;
  logic [ADDR_WIDTH-1:0] sidx_q, nsl_q, start_q, end_q, lastidx_q;
  logic [4:0]            shift_q;
  logic [31:0]           frame_count_q;
  logic                  sat_q;
  logic [2:0]            cnt_q;
  logic [1:0]            wptr_q, rptr_q;

  logic                  dump_mode, accept, pulse_end, frame_end, latch_cfg, push, pop;
  logic [ADDR_WIDTH-1:0] nsl_in, lastidx_in;

  // A FIRST pulse that is also the last one produces output like DUMP.
  assign dump_mode  = (state_q == DUMP) || (state_q == FIRST && npl_q == 16'd0);
  // Count >= 2 leaves room for the two beats already in the pipeline plus this one.
  assign s_axis_tready = (state_q != IDLE) && !(dump_mode && cnt_q >= 3'd2);
  assign accept     = s_axis_tvalid && s_axis_tready;
  assign pulse_end  = accept && (sidx_q == nsl_q);
  assign frame_end  = pulse_end && (pidx_q == npl_q);
  assign latch_cfg  = enable && (state_q == IDLE || frame_end);
  assign nsl_in     = ADDR_WIDTH'(n_samples - (ADDR_WIDTH+1)'(1));
  assign lastidx_in = (end_index < nsl_in) ? end_index : nsl_in;

  always_ff @(posedge aclk) begin
    if (latch_cfg) begin
      npl_q     <= (n_pulses == 16'd0) ? 16'd0 : n_pulses - 16'd1;
      nsl_q     <= nsl_in;
      start_q   <= start_index;
      end_q     <= end_index;
      lastidx_q <= lastidx_in;
      shift_q   <= out_shift;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      sidx_q        <= '0;
      pidx_q        <= '0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= FIRST;
            sidx_q  <= '0;
            pidx_q  <= '0;
          end
        end
        default: begin
          if (accept) begin
            if (!pulse_end) begin
              sidx_q <= sidx_q + ADDR_WIDTH'(1);
            end else begin
              sidx_q <= '0;
              if (frame_end) begin
                frame_count_q <= frame_count_q + 32'd1;
                pidx_q        <= '0;
                state_q       <= enable ? FIRST : IDLE;
              end else begin
                pidx_q  <= pidx_q + 16'd1;
                state_q <= (pidx_q + 16'd1 == npl_q) ? DUMP : ACCUM;
              end
            end
          end
        end
      endcase
    end
  end

  // Stage 0: accepted beat, its flags and the RAM read
  logic                      vld_p0, first_p0, push_p0, last_p0;
  logic [ADDR_WIDTH-1:0]     idx_p0;
  logic [N_CH*IN_WIDTH-1:0]  samp_p0;
  logic [AW-1:0]             rd_p0, sum_c;
  logic [4:0]                shift_p0;
  logic [AW-1:0]             mem_q [2**ADDR_WIDTH];

  always_ff @(posedge aclk) begin
    if (accept) begin
      samp_p0  <= s_axis_tdata;
      idx_p0   <= sidx_q;
      first_p0 <= (state_q == FIRST);
      push_p0  <= dump_mode && (sidx_q >= start_q) && (sidx_q <= end_q);
      last_p0  <= (sidx_q == lastidx_q);
      shift_p0 <= shift_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept && state_q != FIRST) rd_p0 <= mem_q[sidx_q];
    if (vld_p0) mem_q[idx_p0] <= sum_c;
  end

  always_comb begin
    sum_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      sum_c[c*ACC_WIDTH +: ACC_WIDTH] = (first_p0 ? {ACC_WIDTH{1'b0}} : rd_p0[c*ACC_WIDTH +: ACC_WIDTH])
                                        + sext_fn(samp_p0[c*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // Stage 1: write-back done, sum registered for output formatting
  logic          vld_p1, push_p1, last_p1;
  logic [AW-1:0] sum_p1;
  logic [4:0]    shift_p1;
  logic [OW-1:0] out_c;
  logic          clip_c;

  always_ff @(posedge aclk) begin
    if (vld_p0) begin
      sum_p1   <= sum_c;
      push_p1  <= push_p0;
      last_p1  <= last_p0;
      shift_p1 <= shift_p0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  always_comb begin
    out_c  = '0;
    clip_c = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      out_c[c*OUT_WIDTH +: OUT_WIDTH] = sat_fn(shr_fn(sum_p1[c*ACC_WIDTH +: ACC_WIDTH], shift_p1));
      clip_c = clip_c | clip_fn(shr_fn(sum_p1[c*ACC_WIDTH +: ACC_WIDTH], shift_p1));
    end
  end

  // Stage 2: saturated result pushed into the output FIFO
  logic [OW:0] fifo_q [4];

  assign push = vld_p1 && push_p1;
  assign pop  = (cnt_q != 3'd0) && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
      if (push && clip_c) sat_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_q[wptr_q] <= {last_p1, out_c};
  end

  assign m_axis_tvalid = (cnt_q != 3'd0);
  assign m_axis_tdata  = fifo_q[rptr_q][OW-1:0];
  assign m_axis_tlast  = (cnt_q != 3'd0) && fifo_q[rptr_q][OW];
  assign frame_count   = frame_count_q;
  assign sat_flag      = sat_q;
endmodule
